keccak_state_unloader: RTL
==========================

// Module: keccak_state_unloader
// PURPOSE
//  Reader side of the Keccak state array. Captures a full 5x5xLANE_SIZE state (indexed [x][y], as
//  driven into the theta/rho/pi/chi/iota step modules). Streams the first RATE_LANES lanes out one
//  lane per handshake, in FIPS-202 lane order (i = x + 5*y). Sits between the permutation core and
//  the squeeze/digest output path.
// PARAMETERS
//  RATE_LANES  17  lanes streamed per load (1..25); 17 = SHA3-256 rate (1088 bits)
//  (ROW_SIZE=5, COL_SIZE=5, LANE_SIZE=64 taken from keccak_pkg, not overridable here)
// PORTS
//  clk         in   1                             system clock, rising edge
//  rst         in   1                             asynchronous, active-high reset
//  load_valid  in   1                             state_in holds a state to unload
//  load_ready  out  1                             unloader can accept a new state
//  state_in    in   [ROW_SIZE][COL_SIZE][LANE_SIZE]  state array, index [x][y]
//  lane_valid  out  1                             lane_data/lane_idx/lane_last valid
//  lane_ready  in   1                             downstream accepts current lane
//  lane_data   out  LANE_SIZE                     current lane
//  lane_idx    out  5                             lane index i = x + 5*y of lane_data
//  lane_last   out  1                             high on lane RATE_LANES-1
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; load_ready=1, lane_valid=0, lane_data=0, lane_idx=0,
//    lane_last=0, internal state copy cleared.
//  - FSM states: IDLE, STREAM.
//  - IDLE: load_ready=1, lane_valid=0.
//    On load_valid & load_ready, at the clock edge: register all 25 lanes, counter<=0, go to STREAM.
//  - STREAM: load_ready=0. lane_valid=1.
//    lane_data = stored[i%5][i/5]; lane_idx=i; lane_last=(i==RATE_LANES-1).
//  - Lane handshake: transfer on lane_valid & lane_ready. Counter advances by 1 per transfer.
//    While stalled, lane_data/lane_idx/lane_last are held stable.
//  - Transfer with lane_last=1: next state IDLE, lane_valid=0 next cycle.
//    load_ready returns the following cycle, so there is one bubble between back-to-back states.
//  - Latency: load handshake at edge N -> first lane valid from edge N (visible in cycle N+1).
//    One lane per cycle when lane_ready is held high. RATE_LANES+1 cycles per state, minimum.
//  - state_in is sampled only at the load handshake. Later changes to state_in have no effect
//    on the lanes being streamed.
//  - Outputs are registered (no combinational path from lane_ready/load_valid to lane_* outputs);
//    load_ready is a pure function of FSM state.
//  - Counter is 5 bits; never exceeds RATE_LANES-1. RATE_LANES=1 -> single lane, lane_last=1 on it.
//  - RATE_LANES outside 1..25: elaboration-time $fatal.
//  - rst asserted mid-STREAM: stream aborted at once, outputs to reset values; no partial resume.
// CONFIGURATION
//  KECCAK_UNLOAD_INV_PI_EN defined: the stored state is passed through inverse pi before
//    streaming. Lane at (x,y) = stored[y][(2x+3y)%5]. This undoes pi_step
//    (A'[x][y] = A[(x+3y)%5][x]), so a pi_step output unloads in pre-pi order. Same timing.
//  Undefined (default): lanes streamed directly from the stored state, no re-ordering logic.
// TESTING
//  T1 reset: rst=1 mid-stream at lane 7 -> next sample lane_valid=0, load_ready=1, lane_data=0.
//  T2 sequential: state_in[x][y]=5x+y, lane_ready=1 -> 17 lanes, one per cycle.
//     lane_data(i) = 5*(i%5)+(i/5) for i=0..16; lane_last only at i=16;
//     load_ready back after 18 cycles.
//  T3 backpressure: lane_ready random 50% -> same 17-lane sequence as T2.
//     Outputs stable whenever valid&!ready; no lane dropped or repeated.
//  T4 single bit: state_in[1][0]=64'h1, all other lanes 0 -> lane_idx 1 carries 64'h1; lanes
//     0,2..16 are 0. With KECCAK_UNLOAD_INV_PI_EN, input = pi_step output of that state -> same result.
//  T5 isolation: change state_in every cycle during STREAM; hold load_valid=1 -> streamed lanes
//     equal the snapshot taken at load. Second state accepted only after lane_last transfer.
//  T6 RATE_LANES=25 and RATE_LANES=1 -> 25 lanes ending idx 24 / single lane idx 0, lane_last=1.

Source files
------------

// File: rtl/keccak_state_unloader.sv
// Keccak state unloader: snapshots a 5x5 lane state and streams the first RATE_LANES lanes in
// FIPS-202 order (i = x + 5*y). Define KECCAK_UNLOAD_INV_PI_EN to undo pi_step before streaming.

package keccak_pkg;
  localparam int unsigned ROW_SIZE  = 5;
  localparam int unsigned COL_SIZE  = 5;
  localparam int unsigned LANE_SIZE = 64;
  localparam int unsigned NUM_LANES = ROW_SIZE * COL_SIZE;
  localparam int unsigned IDX_W     = 5;
endpackage

module keccak_state_unloader
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_LANES = 17
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               load_valid,
  output logic                                               load_ready,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_in,
  output logic                                               lane_valid,
  input  logic                                               lane_ready,
  output logic [LANE_SIZE-1:0]                               lane_data,
  output logic [IDX_W-1:0]                                   lane_idx,
  output logic                                               lane_last
);

  if (RATE_LANES == 0 || RATE_LANES > NUM_LANES) begin : g_bad_rate
    $fatal(1, "keccak_state_unloader: RATE_LANES must be in 1..25");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                                state;
  logic [NUM_LANES-1:0][LANE_SIZE-1:0]   in_lanes;
  logic [NUM_LANES-1:0][LANE_SIZE-1:0]   stored;
  logic [IDX_W-1:0]                      nxt_idx;

  // Flatten the [x][y] input into streaming order so the datapath is a single indexed read.
  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
`ifdef KECCAK_UNLOAD_INV_PI_EN
      assign in_lanes[x + 5*y] = state_in[y][(2*x + 3*y) % 5];
`else
      assign in_lanes[x + 5*y] = state_in[x][y];
`endif
    end
  end

  assign nxt_idx = lane_idx + IDX_W'(1);

  // lane_idx doubles as the stream counter; it never passes LAST_IDX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      lane_valid <= 1'b0;
      lane_data  <= '0;
      lane_idx   <= '0;
      lane_last  <= 1'b0;
      stored     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            stored     <= in_lanes;
            lane_data  <= in_lanes[0];
            lane_idx   <= '0;
            lane_last  <= (LAST_IDX == '0);
            lane_valid <= 1'b1;
            load_ready <= 1'b0;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (lane_ready) begin
            if (lane_last) begin
              lane_valid <= 1'b0;
              lane_last  <= 1'b0;
              load_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              lane_idx  <= nxt_idx;
              lane_data <= stored[nxt_idx];
              lane_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          lane_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
